// File: rtl/e203_itcm_icb_slv.sv
// ---------------------------------------------------------------------------
// e203_itcm_icb_slv
//   ICB responder for the ITCM. Accepts ICB read/write commands, drives a
//   single-port synchronous SRAM with 1-cycle read latency, and returns
//   responses in order. At most one response is outstanding. Back-to-back
//   throughput is one access per cycle while the response side keeps
//   rsp_ready high.
//
// Ports
//   clk, rst               core clock, synchronous active-high reset
//   icb_cmd_*              ICB command channel (valid/ready, addr, read,
//                          wdata, wmask)
//   icb_rsp_*              ICB response channel (valid/ready, err, rdata)
//   ram_cs/we/addr/wem/din SRAM control, combinational from the command and
//                          gated by the command handshake
//   ram_dout               SRAM read data, valid the cycle after a read cs
//   itcm_holdup            ram_dout still holds the data of the last read
//   itcm_active            clock-gating hint (pending rsp or incoming cmd)
//
// Handshake rule: a transfer happens on a channel in every cycle where its
// valid and ready are both high at the rising clock edge. A valid source
// keeps its payload stable until that transfer.
//
// Configuration macro
//   E203_ITCM_HOLDUP_EN  when defined, implements the holdup flag; otherwise
//                        itcm_holdup is tied to 0.
// ---------------------------------------------------------------------------
module e203_itcm_icb_slv #(
  parameter int          AW   = 16,
  parameter int          DW   = 64,
  parameter int          MW   = 8,
  parameter logic [31:0] BASE = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        icb_cmd_valid,
  output logic                        icb_cmd_ready,
  input  logic [31:0]                 icb_cmd_addr,
  input  logic                        icb_cmd_read,
  input  logic [DW-1:0]               icb_cmd_wdata,
  input  logic [MW-1:0]               icb_cmd_wmask,
  output logic                        icb_rsp_valid,
  input  logic                        icb_rsp_ready,
  output logic                        icb_rsp_err,
  output logic [DW-1:0]               icb_rsp_rdata,
  output logic                        ram_cs,
  output logic                        ram_we,
  output logic [AW-$clog2(MW)-1:0]    ram_addr,
  output logic [MW-1:0]               ram_wem,
  output logic [DW-1:0]               ram_din,
  input  logic [DW-1:0]               ram_dout,
  output logic                        itcm_holdup,
  output logic                        itcm_active
);

  localparam int OW  = $clog2(MW);
  localparam int RAW = AW - OW;

  // Response-side state
  logic          rsp_pend_q, rsp_pend_d;
  logic          fresh_q, fresh_d;   // ram_dout still carries this rsp's data
  logic          err_q, err_d;
  logic          rd_q, rd_d;
  logic [DW-1:0] hold_q, hold_d;     // captured read data while stalled

  logic cmd_accept;
  logic in_range;
  logic rsp_hsk;

  // Byte-offset bits never reach the word-addressed SRAM.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^icb_cmd_addr[OW-1:0];

  assign in_range      = (icb_cmd_addr[31:AW] == BASE[31:AW]);
  assign icb_cmd_ready = ~rsp_pend_q | icb_rsp_ready;
  assign cmd_accept    = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hsk       = rsp_pend_q & icb_rsp_ready;

  // SRAM drive: nothing reaches the macro unless the command is accepted.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wem  = '0;
    ram_din  = '0;
    if (cmd_accept) begin
      ram_addr = icb_cmd_addr[AW-1:OW];
      if (in_range) begin
        ram_cs = 1'b1;
        ram_we = ~icb_cmd_read;
        if (!icb_cmd_read) begin
          ram_wem = icb_cmd_wmask;
          ram_din = icb_cmd_wdata;
        end
      end
    end
  end

  // Next-state logic. An accept always reloads the response state, which
  // covers both the idle case and the retire-plus-accept case.
  always_comb begin
    rsp_pend_d = rsp_pend_q;
    fresh_d    = fresh_q;
    err_d      = err_q;
    rd_d       = rd_q;
    hold_d     = hold_q;
    if (cmd_accept) begin
      rsp_pend_d = 1'b1;
      fresh_d    = 1'b1;
      err_d      = ~in_range;
      rd_d       = icb_cmd_read;
    end else if (rsp_hsk) begin
      rsp_pend_d = 1'b0;
      fresh_d    = 1'b0;
    end else if (rsp_pend_q && fresh_q) begin
      // First stall cycle: the SRAM output may change afterwards, so keep
      // a private copy for the rest of the stall.
      hold_d  = ram_dout;
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q <= 1'b0;
      fresh_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      hold_q     <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      fresh_q    <= fresh_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      hold_q     <= hold_d;
    end
  end

  assign icb_rsp_valid = rsp_pend_q;
  assign icb_rsp_err   = err_q;
  assign icb_rsp_rdata = (err_q | ~rd_q) ? '0 : (fresh_q ? ram_dout : hold_q);
  assign itcm_active   = rsp_pend_q | icb_cmd_valid;

`ifdef E203_ITCM_HOLDUP_EN
  // Set by an in-range read, cleared by an in-range write; error accepts and
  // idle cycles leave the SRAM output untouched, so the flag is kept.
  logic holdup_q, holdup_d;

  always_comb begin
    holdup_d = holdup_q;
    if (cmd_accept && in_range) begin
      holdup_d = icb_cmd_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdup_q <= 1'b0;
    end else begin
      holdup_q <= holdup_d;
    end
  end

  assign itcm_holdup = holdup_q;
`else
  assign itcm_holdup = 1'b0;
`endif

endmodule

// File: tb/tb_e203_itcm_icb_slv.sv
// ---------------------------------------------------------------------------
// tb_e203_itcm_icb_slv
//   Bench for e203_itcm_icb_slv. Contains a behavioural SRAM whose output is
//   random noise except in the cycle after a read, a reference memory image
//   updated at command issue, an expected-response queue and a monitor.
// ---------------------------------------------------------------------------
module tb_e203_itcm_icb_slv;

  localparam int AW    = 16;
  localparam int DW    = 64;
  localparam int MW    = 8;
  localparam int WORDS = 1 << (AW - 3);

  logic            clk = 1'b0;
  logic            rst;
  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [31:0]     icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [MW-1:0]   icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic            icb_rsp_err;
  logic [DW-1:0]   icb_rsp_rdata;
  logic            ram_cs;
  logic            ram_we;
  logic [AW-4:0]   ram_addr;
  logic [MW-1:0]   ram_wem;
  logic [DW-1:0]   ram_din;
  logic [DW-1:0]   ram_dout;
  logic            itcm_holdup;
  logic            itcm_active;

  e203_itcm_icb_slv dut (
    .clk           (clk),
    .rst           (rst),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_cmd_wmask (icb_cmd_wmask),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_err   (icb_rsp_err),
    .icb_rsp_rdata (icb_rsp_rdata),
    .ram_cs        (ram_cs),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wem       (ram_wem),
    .ram_din       (ram_din),
    .ram_dout      (ram_dout),
    .itcm_holdup   (itcm_holdup),
    .itcm_active   (itcm_active)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:WORDS-1];
  logic [DW-1:0] rd_word = '0;
  logic          dout_v  = 1'b0;
  logic [DW-1:0] noise   = '0;

  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      for (int b = 0; b < MW; b++)
        if (ram_wem[b]) sram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
    rd_word <= sram[ram_addr];
    dout_v  <= ram_cs & ~ram_we;
    noise   <= {$urandom, $urandom};
  end
  assign ram_dout = dout_v ? rd_word : noise;

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0] ref_mem [0:WORDS-1];
  logic [DW:0]   exp_q[$];          // {err, rdata}
  logic          holdup_exp;
  int            checks = 0;
  int            errors = 0;
  int            rsp_count = 0;
  int            rdy_mode = 1;      // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // rsp_ready driver
  initial begin
    icb_rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       icb_rsp_ready = 1'b1;
        2:       icb_rsp_ready = 1'b0;
        default: icb_rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops one expectation per response handshake.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst && icb_rsp_valid && icb_rsp_ready) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got err=%b rdata=%h expected no response", icb_rsp_err, icb_rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_err", {63'd0, icb_rsp_err}, {63'd0, e[DW]});
          chk("rsp_rdata", icb_rsp_rdata, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    icb_cmd_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one command and waits for its acceptance; leaves valid high so
  // consecutive calls produce back-to-back traffic.
  task automatic issue(input logic [31:0] a, input logic rd,
                       input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    int   n;
    logic ok;
    logic inr;
    logic [AW-4:0] w;
    icb_cmd_valid = 1'b1;
    icb_cmd_addr  = a;
    icb_cmd_read  = rd;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    inr = (a[31:16] == 16'h8000);
    w   = a[15:3];
    n   = 0;
    ok  = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (icb_cmd_ready) ok = 1'b1;
      else begin
        chk("ram_cs_while_stalled", {63'd0, ram_cs}, 64'd0);
        n++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got no accept expected accept within 50 cycles");
      icb_cmd_valid = 1'b0;
      return;
    end
    chk("ram_cs", {63'd0, ram_cs}, {63'd0, inr});
    if (inr) begin
      chk("ram_we", {63'd0, ram_we}, {63'd0, ~rd});
      chk("ram_addr", {51'd0, ram_addr}, {51'd0, w});
      chk("ram_wem", {56'd0, ram_wem}, rd ? 64'd0 : {56'd0, wm});
    end
    if (!inr) exp_q.push_back({1'b1, {DW{1'b0}}});
    else if (rd) exp_q.push_back({1'b0, ref_mem[w]});
    else begin
      for (int b = 0; b < MW; b++)
        if (wm[b]) ref_mem[w][b*8 +: 8] = wd[b*8 +: 8];
      exp_q.push_back({1'b0, {DW{1'b0}}});
    end
`ifdef E203_ITCM_HOLDUP_EN
    if (inr) holdup_exp = rd;
`endif
    @(posedge clk);
    #1;
    chk("holdup_after_accept", {63'd0, itcm_holdup}, {63'd0, holdup_exp});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    logic [31:0] a;
    rst           = 1'b1;
    icb_cmd_valid = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_read  = 1'b0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    holdup_exp    = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = {$urandom, $urandom};
      ref_mem[i] = sram[i];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
    chk("reset_rsp_err", {63'd0, icb_rsp_err}, 64'd0);
    chk("reset_rdata", icb_rsp_rdata, 64'd0);
    chk("reset_ram_cs", {63'd0, ram_cs}, 64'd0);
    chk("reset_holdup", {63'd0, itcm_holdup}, 64'd0);
    chk("reset_active", {63'd0, itcm_active}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 1: single read, response one cycle after accept
    issue(32'h8000_0008, 1'b1, '0, '0);
    idle(0);
    @(negedge clk);
    chk("read_latency_valid", {63'd0, icb_rsp_valid}, 64'd1);
    idle(2);

    // 2: three back-to-back reads, no bubbles
    base = rsp_count;
    issue(32'h8000_0000, 1'b1, '0, '0);
    issue(32'h8000_0008, 1'b1, '0, '0);
    issue(32'h8000_0010, 1'b1, '0, '0);
    idle(0);
    @(negedge clk);
    #1;
    chk("b2b_rsp_count", 64'(rsp_count - base), 64'd3);
    idle(2);

    // 3: read stalled for 4 cycles while SRAM output is noise
    rdy_mode = 2;
    idle(1);
    issue(32'h8000_0100, 1'b1, '0, '0);
    idle(0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_rsp_valid", {63'd0, icb_rsp_valid}, 64'd1);
      chk("stall_cmd_ready", {63'd0, icb_cmd_ready}, 64'd0);
      chk("stall_ram_cs", {63'd0, ram_cs}, 64'd0);
    end
    rdy_mode = 1;
    idle(3);

    // 4: masked write then read back
    issue(32'h8000_0010, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5, 8'h0F);
    issue(32'h8000_0010, 1'b1, '0, '0);
    idle(2);

    // 5: out-of-range read
    issue(32'h9000_0000, 1'b1, '0, '0);
    idle(2);
    chk("oor_holdup_kept", {63'd0, itcm_holdup}, {63'd0, holdup_exp});

    // 6: holdup across idle/write, then reset in the middle of a stall
    issue(32'h8000_0020, 1'b1, '0, '0);
    idle(5);
    chk("holdup_after_idle", {63'd0, itcm_holdup}, {63'd0, holdup_exp});
    issue(32'h8000_0028, 1'b0, 64'h1122_3344_5566_7788, 8'hF0);
    idle(2);
    issue(32'h8000_0030, 1'b1, '0, '0);
    rdy_mode = 2;
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    holdup_exp = 1'b0;
    rdy_mode = 1;
    @(negedge clk);
    chk("rst_mid_rsp_valid", {63'd0, icb_rsp_valid}, 64'd0);
    chk("rst_mid_holdup", {63'd0, itcm_holdup}, 64'd0);
    chk("rst_mid_cmd_ready", {63'd0, icb_cmd_ready}, 64'd1);
    idle(2);

    // Random traffic with random response back-pressure
    rdy_mode = 0;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) a = {16'h9000, 16'($urandom)};
      else a = {16'h8000, 8'd0, 5'($urandom), 3'($urandom)};
      issue(a, ($urandom_range(0, 9) < 6), {$urandom, $urandom}, 8'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 1;
    idle(6);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
